mcp_sync_rx: RTL and testbench

- Receive side of a multi-channel, multi-cycle-path (MCP) multibit synchronizer, clocked entirely in the destination domain.
- Each channel takes a word from an asynchronous source via a toggle request, synchronizes only the toggle, and captures the word with a recirculation mux.
- It then presents the word to a downstream valid/ready consumer and returns a toggle acknowledge once the word has been consumed.
- It replaces direct multibit flopping across domains (ff_multibit), which corrupts words.

---
 rtl/mcp_sync_pkg.sv | 11 +
 rtl/mcp_rx_channel.sv | 59 +++++
 rtl/mcp_sync_rx.sv | 43 ++++
 tb/tb_mcp_sync_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_sync_pkg.sv
// Shared constants and types for the multi-channel MCP synchronizer receive side.
package mcp_sync_pkg;

  localparam int unsigned NB_DEF          = 8;
  localparam int unsigned NCH_DEF         = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef logic [NB_DEF-1:0] word_t;

endpackage

// File: rtl/mcp_rx_channel.sv
// One MCP receive channel: request-toggle synchronizer, edge detect,
// recirculating holding register and valid/ack/overrun handshake.
module mcp_rx_channel
  import mcp_sync_pkg::*;
#(
  parameter int unsigned NB          = NB_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [NB-1:0] i_data,
  input  logic          i_req,
  input  logic          i_ready,
  input  logic          i_overrun_clr,
  output logic [NB-1:0] o_data,
  output logic          o_valid,
  output logic          o_ack,
  output logic          o_overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_prev_q;
  logic                   new_req_c;
  logic                   consume_c;
  logic                   load_c;

  assign new_req_c = sync_q[SYNC_STAGES-1] ^ req_prev_q;
  assign consume_c = o_valid & i_ready;
  // A new word is only taken when the holding register is free this edge.
  assign load_c    = new_req_c & (~o_valid | i_ready);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_ack      <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_req};
      req_prev_q <= sync_q[SYNC_STAGES-1];
      if (load_c) begin
        o_data <= i_data;
      end
      o_valid <= new_req_c | (o_valid & ~i_ready);
      if (consume_c) begin
        o_ack <= ~o_ack;
      end
      // A request arriving while a word is still held is a source violation.
      if (new_req_c & o_valid) begin
        o_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mcp_sync_rx.sv
// Destination-domain receive side of an NCH-channel multi-cycle-path synchronizer.
module mcp_sync_rx
  import mcp_sync_pkg::*;
#(
  parameter int unsigned NB          = NB_DEF,
  parameter int unsigned NCH         = NCH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NCH*NB-1:0] i_data,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH-1:0]    i_ready,
  input  logic              i_overrun_clr,
  output logic [NCH*NB-1:0] o_data,
  output logic [NCH-1:0]    o_valid,
  output logic [NCH-1:0]    o_ack,
  output logic [NCH-1:0]    o_overrun
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("mcp_sync_rx: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mcp_rx_channel #(
      .NB          (NB),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_data        (i_data[c*NB +: NB]),
      .i_req         (i_req[c]),
      .i_ready       (i_ready[c]),
      .i_overrun_clr (i_overrun_clr),
      .o_data        (o_data[c*NB +: NB]),
      .o_valid       (o_valid[c]),
      .o_ack         (o_ack[c]),
      .o_overrun     (o_overrun[c])
    );
  end

endmodule

// File: tb/tb_mcp_sync_rx.sv
// Bench for mcp_sync_rx: directed vector table, hand-written corner sequences,
// and a randomized asynchronous source checked by an in-order scoreboard.
module tb_mcp_sync_rx;
  import mcp_sync_pkg::*;

  localparam int unsigned NB             = NB_DEF;
  localparam int unsigned NCH            = NCH_DEF;
  localparam int          NWORDS         = 200;
  localparam int          SRC_TICK_LIMIT = 20000;

  logic              clk;
  logic              i_reset;
  logic [NCH*NB-1:0] i_data;
  logic [NCH-1:0]    i_req;
  logic [NCH-1:0]    i_ready;
  logic              i_overrun_clr;
  logic [NCH*NB-1:0] o_data;
  logic [NCH-1:0]    o_valid;
  logic [NCH-1:0]    o_ack;
  logic [NCH-1:0]    o_overrun;

  mcp_sync_rx dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_data        (i_data),
    .i_req         (i_req),
    .i_ready       (i_ready),
    .i_overrun_clr (i_overrun_clr),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_ack         (o_ack),
    .o_overrun     (o_overrun)
  );

  // Destination period 20 units; the random source runs with period 14 (7:10 ratio).
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    int    ch;
    word_t word;
    int    stall;
    logic  exp_ack;
  } vec_t;

  vec_t           vecs [5];
  int             chk_cnt;
  int             pass_cnt;
  logic [NCH-1:0] req_state;
  word_t          exp_q [NCH][$];
  int             st    [NCH];
  int             sent  [NCH];
  int             recv  [NCH];
  logic [NCH-1:0] ack_s1;
  logic [NCH-1:0] ack_s2;
  bit             done;

  function automatic word_t ch_data(input int c);
    return o_data[c*NB +: NB];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input word_t w);
    i_data[ch*NB +: NB] = w;
    req_state[ch]       = ~req_state[ch];
    i_req[ch]           = req_state[ch];
  endtask

  // One source transfer: word visible 3 edges after the toggle, ack after consume.
  task automatic xfer(input int ch, input word_t w, input int stall, input logic exp_ack);
    i_ready[ch] = (stall == 0);
    send(ch, w);
    tick();
    check("lat_edge1_valid", o_valid[ch], 1'b0);
    tick();
    check("lat_edge2_valid", o_valid[ch], 1'b0);
    tick();
    check("capture_valid", o_valid[ch], 1'b1);
    check("capture_data", ch_data(ch), w);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        tick();
        check("stall_hold", {o_valid[ch], ch_data(ch), o_ack[ch]}, {1'b1, w, ~exp_ack});
      end
      i_ready[ch] = 1'b1;
    end
    tick();
    check("consume", {o_valid[ch], o_ack[ch], ch_data(ch)}, {1'b0, exp_ack, w});
    i_ready[ch] = 1'b0;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    req_state = '0;
    i_reset = 1'b1;
    i_data = '0;
    i_req = '0;
    i_ready = '0;
    i_overrun_clr = 1'b0;

    vecs[0] = '{ch: 0, word: 8'hA5, stall: 0,  exp_ack: 1'b1};
    vecs[1] = '{ch: 1, word: 8'h3C, stall: 10, exp_ack: 1'b1};
    vecs[2] = '{ch: 3, word: 8'h5A, stall: 0,  exp_ack: 1'b1};
    vecs[3] = '{ch: 0, word: 8'hFF, stall: 3,  exp_ack: 1'b0};
    vecs[4] = '{ch: 2, word: 8'h81, stall: 1,  exp_ack: 1'b1};

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {o_data, o_valid, o_ack, o_overrun}, 44'd0);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", {o_data, o_valid, o_ack, o_overrun}, 44'd0);
    end

    foreach (vecs[i]) xfer(vecs[i].ch, vecs[i].word, vecs[i].stall, vecs[i].exp_ack);

    // Overrun on channel 2: second word dropped, flag sticky until cleared
    send(2, 8'h11);
    repeat (3) tick();
    check("ovr_first_word", {o_valid[2], ch_data(2)}, {1'b1, 8'h11});
    send(2, 8'h22);
    repeat (3) tick();
    check("ovr_data_kept", ch_data(2), 8'h11);
    check("ovr_flags", {o_valid[2], o_ack[2], o_overrun}, {1'b1, 1'b1, 4'b0100});
    i_overrun_clr = 1'b1;
    tick();
    i_overrun_clr = 1'b0;
    check("ovr_clear", o_overrun, 4'b0000);
    i_ready[2] = 1'b1;
    tick();
    i_ready[2] = 1'b0;
    check("ovr_consume", {o_valid[2], o_ack[2]}, {1'b0, 1'b0});

    // New request and consume on the same edge (channel 1), set beats clear
    send(1, 8'h5C);
    repeat (3) tick();
    check("sim_first_word", {o_valid[1], ch_data(1)}, {1'b1, 8'h5C});
    send(1, 8'hC5);
    repeat (2) tick();
    i_ready[1] = 1'b1;
    i_overrun_clr = 1'b1;
    tick();
    i_ready[1] = 1'b0;
    i_overrun_clr = 1'b0;
    check("sim_replace", {o_valid[1], o_ack[1], ch_data(1)}, {1'b1, 1'b0, 8'hC5});
    check("sim_overrun", o_overrun, 4'b0010);
    i_ready[1] = 1'b1;
    tick();
    i_ready[1] = 1'b0;
    check("sim_consume", {o_valid[1], o_ack[1]}, {1'b0, 1'b1});
    i_overrun_clr = 1'b1;
    tick();
    i_overrun_clr = 1'b0;
    check("sim_clear", o_overrun, 4'b0000);

    // Reset one cycle after a channel-3 toggle; source toggles restart at 0
    send(3, 8'h77);
    tick();
    i_reset = 1'b1;
    i_req = '0;
    req_state = '0;
    tick();
    check("midreset_outputs", {o_data, o_valid, o_ack, o_overrun}, 44'd0);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_idle", {o_valid, o_ack}, 8'd0);
    end
    xfer(3, 8'hC3, 0, 1'b1);

    // Randomized asynchronous source against an in-order scoreboard
    for (int c = 0; c < NCH; c++) begin
      st[c] = 0;
      sent[c] = 0;
      recv[c] = 0;
    end
    ack_s1 = o_ack;
    ack_s2 = o_ack;
    done = 1'b0;
    fork
      begin : src_model
        bit    all_done;
        word_t w;
        all_done = 1'b0;
        #2;
        for (int t = 0; t < SRC_TICK_LIMIT; t++) begin
          #14;
          all_done = 1'b1;
          for (int c = 0; c < NCH; c++) begin
            ack_s2[c] = ack_s1[c];
            ack_s1[c] = o_ack[c];
            case (st[c])
              0: if (sent[c] < NWORDS) begin
                all_done = 1'b0;
                if ($urandom % 2 == 0) begin
                  w = word_t'($urandom);
                  i_data[c*NB +: NB] = w;
                  exp_q[c].push_back(w);
                  st[c] = 1;
                end
              end
              1: begin
                all_done = 1'b0;
                req_state[c] = ~req_state[c];
                i_req[c] = req_state[c];
                st[c] = 2;
              end
              default: begin
                all_done = 1'b0;
                if (ack_s2[c] == req_state[c]) begin
                  sent[c]++;
                  st[c] = 0;
                end
              end
            endcase
          end
          if (all_done) break;
        end
        check("src_completed", all_done, 1'b1);
        done = 1'b1;
      end
      begin : consumer
        while (!done) begin
          @(posedge clk);
          #1;
          i_ready = NCH'($urandom);
        end
      end
      begin : monitor
        while (!done) begin
          @(negedge clk);
          for (int c = 0; c < NCH; c++) begin
            if (o_valid[c] && i_ready[c]) begin
              check("sb_pending", 64'(exp_q[c].size()), 64'd1);
              if (exp_q[c].size() > 0) check("sb_word", ch_data(c), exp_q[c].pop_front());
              recv[c]++;
            end
          end
        end
      end
    join
    i_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      check("sb_recv_count", 64'(recv[c]), 64'(NWORDS));
      check("sb_queue_empty", 64'(exp_q[c].size()), 64'd0);
    end
    check("rand_no_overrun", o_overrun, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
